dm_responder: RTL and testbench

Memory-side responder for the CPU's data-memory load/store path: accepts one request at a time over a req/ack handshake, inserts a configurable number of wait states, and then commits a store or returns load data. It holds the 64×32 data RAM, exposes `busy` so the pipeline can freeze its buffers, and provides an independent combinational read port for the seven-segment RAM display.

---
 rtl/dm_resp_pkg.sv | 16 +
 rtl/dm_halfword_lane.sv | 23 ++
 rtl/dm_responder.sv | 168 ++++++++++++++++
 tb/tb_dm_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_resp_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int DM_WORD_W = 32;
  localparam int DM_HALF_W = 16;
  // Wait-state counter width; holds WAIT_CYCLES in 0..15
  localparam int DM_CNT_W  = 4;

endpackage

// File: rtl/dm_halfword_lane.sv
// Half-word lane: merges a store half into a word and extracts a
// sign-extended half for loads. Purely combinational.
module dm_halfword_lane
  import dm_resp_pkg::*;
(
  input  logic [DM_WORD_W-1:0] word_i,        // current memory word
  input  logic [DM_HALF_W-1:0] half_wdata_i,  // half to be stored
  input  logic                 sel_i,         // 0 = bits 15:0, 1 = bits 31:16
  output logic [DM_WORD_W-1:0] merged_o,      // word with selected half replaced
  output logic [DM_WORD_W-1:0] load_o         // selected half, sign-extended
);

  logic [DM_HALF_W-1:0] sel_half;

  // Replace only the selected half; the other half passes through
  assign merged_o = sel_i ? {half_wdata_i, word_i[DM_HALF_W-1:0]}
                          : {word_i[DM_WORD_W-1:DM_HALF_W], half_wdata_i};

  // Pick the addressed half and sign-extend it
  assign sel_half = sel_i ? word_i[DM_WORD_W-1:DM_HALF_W] : word_i[DM_HALF_W-1:0];
  assign load_o   = {{(DM_WORD_W-DM_HALF_W){sel_half[DM_HALF_W-1]}}, sel_half};

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time over req/ack, WAIT_CYCLES
// wait states, then a store commit or load return. Holds the data RAM and
// a combinational display read port.
// Optional feature macro: DM_RESP_HALF_EN enables half-word accesses;
// without it half and addr[0] are ignored and every access is a full word.
//
// Handshake: the initiator raises req with we/half/addr/wdata and holds it
// until ack. Fields are latched at the capture edge in IDLE; ack is a
// one-cycle strobe, and a req still high during the ack cycle is only
// re-sampled once the responder is back in IDLE.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic                 half,
  input  logic [ADDR_W:0]      addr,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic [31:0]          rdata,
  output logic                 busy,
  input  logic [ADDR_W-1:0]    disp_addr,
  output logic [31:0]          disp_data
);

  localparam int DEPTH = 1 << ADDR_W;

  dm_state_e              state_q;
  logic [DM_CNT_W-1:0]    cnt_q;
  logic                   we_q;
  logic [ADDR_W:0]        addr_q;
  logic [DM_WORD_W-1:0]   wdata_q;
  logic                   ack_q;
  logic                   busy_q;
  logic [DM_WORD_W-1:0]   rdata_q;
  logic [DM_WORD_W-1:0]   mem_q [DEPTH];

  // Commit-side view of the access. With zero wait states the commit
  // lands on the capture edge itself, so the live inputs are used while
  // in IDLE and the latched copies otherwise.
  logic                   in_idle;
  logic                   go_resp;
  logic                   c_we;
  logic [ADDR_W:0]        c_addr;
  logic [DM_WORD_W-1:0]   c_wdata;
  logic [ADDR_W-1:0]      c_word;
  logic [DM_WORD_W-1:0]   cur_word;
  logic [DM_WORD_W-1:0]   store_word_d;
  logic [DM_WORD_W-1:0]   load_word_d;
  logic [DM_WORD_W-1:0]   resp_data_d;

  assign in_idle  = (state_q == ST_IDLE);
  assign go_resp  = (in_idle && req && (WAIT_CYCLES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == DM_CNT_W'(1)));
  assign c_we     = in_idle ? we    : we_q;
  assign c_addr   = in_idle ? addr  : addr_q;
  assign c_wdata  = in_idle ? wdata : wdata_q;
  assign c_word   = c_addr[ADDR_W:1];
  assign cur_word = mem_q[c_word];

`ifdef DM_RESP_HALF_EN
  logic                   half_q;
  logic                   c_half;
  logic [DM_WORD_W-1:0]   lane_merged;
  logic [DM_WORD_W-1:0]   lane_load;

  assign c_half = in_idle ? half : half_q;

  dm_halfword_lane u_lane (
    .word_i       (cur_word),
    .half_wdata_i (c_wdata[DM_HALF_W-1:0]),
    .sel_i        (c_addr[0]),
    .merged_o     (lane_merged),
    .load_o       (lane_load)
  );

  assign store_word_d = c_half ? lane_merged : c_wdata;
  assign load_word_d  = c_half ? lane_load   : cur_word;
`else
  // Half-select inputs have no effect in the full-word-only build
  logic unused_half_bits;
  assign unused_half_bits = ^{half, c_addr[0]};

  assign store_word_d = c_wdata;
  assign load_word_d  = cur_word;
`endif

  // Stores return zero on rdata; loads return the (possibly extracted) word
  assign resp_data_d = c_we ? '0 : load_word_d;

  // Request FSM: capture, count wait states, strobe ack, track busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
`ifdef DM_RESP_HALF_EN
      half_q  <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
`ifdef DM_RESP_HALF_EN
            half_q  <= half;
`endif
            cnt_q   <= DM_CNT_W'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            if (go_resp) begin
              state_q <= ST_RESP;
              ack_q   <= 1'b1;
              rdata_q <= resp_data_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - DM_CNT_W'(1);
          if (go_resp) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            rdata_q <= resp_data_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data RAM: cleared on reset, written on the edge entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (go_resp && c_we) begin
      mem_q[c_word] <= store_word_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign disp_data = mem_q[disp_addr];

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with two wait states and
// one with zero wait states, sharing clock and reset. Half-word vectors
// follow DM_RESP_HALF_EN.
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst;

  // Clock / reset
  always #5 clk = ~clk;

  logic        a_req, a_we, a_half;
  logic [6:0]  a_addr;
  logic [31:0] a_wdata;
  logic [5:0]  a_disp_addr;
  logic        a_ack, a_busy;
  logic [31:0] a_rdata, a_disp_data;

  logic        z_req, z_we, z_half;
  logic [6:0]  z_addr;
  logic [31:0] z_wdata;
  logic [5:0]  z_disp_addr;
  logic        z_ack, z_busy;
  logic [31:0] z_rdata, z_disp_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  dm_responder #(.WAIT_CYCLES(2), .ADDR_W(6)) u_dut (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .half(a_half),
    .addr(a_addr), .wdata(a_wdata), .ack(a_ack), .rdata(a_rdata),
    .busy(a_busy), .disp_addr(a_disp_addr), .disp_data(a_disp_data)
  );

  dm_responder #(.WAIT_CYCLES(0), .ADDR_W(6)) u_dut_z (
    .clk(clk), .rst(rst), .req(z_req), .we(z_we), .half(z_half),
    .addr(z_addr), .wdata(z_wdata), .ack(z_ack), .rdata(z_rdata),
    .busy(z_busy), .disp_addr(z_disp_addr), .disp_data(z_disp_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver: one access on instance A. cyc counts cycles after the capture
  // edge until ack is seen (99 on timeout).
  task automatic a_access(input logic w, input logic h, input logic [6:0] ad,
                          input logic [31:0] wd, output int cyc,
                          output logic [31:0] rd, output logic bmid,
                          output logic bafter, output logic [31:0] rhold);
    @(negedge clk);
    a_req = 1'b1; a_we = w; a_half = h; a_addr = ad; a_wdata = wd;
    @(posedge clk); #1;
    cyc  = 1;
    bmid = a_busy;
    while (!a_ack && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!a_ack) cyc = 99;
    rd = a_rdata;
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0; a_half = 1'b0; a_wdata = 32'h0;
    @(posedge clk); #1;
    bafter = a_busy;
    rhold  = a_rdata;
  endtask

  task automatic a_store(input logic h, input logic [6:0] ad, input logic [31:0] wd,
                         input string tag);
    int cyc; logic [31:0] rd, rhold; logic bmid, bafter;
    a_access(1'b1, h, ad, wd, cyc, rd, bmid, bafter, rhold);
    check_eq({tag, "_lat"}, cyc, 3);
    check_eq({tag, "_rdata0"}, rd, 32'h0);
    check_eq({tag, "_busy_mid"}, bmid, 1'b1);
    check_eq({tag, "_busy_after"}, bafter, 1'b0);
  endtask

  task automatic a_load(input logic h, input logic [6:0] ad, input logic [31:0] exp,
                        input string tag);
    int cyc; logic [31:0] rd, rhold, e; logic bmid, bafter;
    exp_q.push_back(exp);
    a_access(1'b0, h, ad, 32'h0, cyc, rd, bmid, bafter, rhold);
    e = exp_q.pop_front();
    check_eq({tag, "_lat"}, cyc, 3);
    check_eq({tag, "_rdata"}, rd, e);
    check_eq({tag, "_rdata_hold"}, rhold, e);
  endtask

  initial begin
    int acks;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_half = 0; a_addr = '0; a_wdata = '0; a_disp_addr = '0;
    z_req = 0; z_we = 0; z_half = 0; z_addr = '0; z_wdata = '0; z_disp_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset defaults
    a_disp_addr = 6'd5; #1;
    check_eq("rst_disp5", a_disp_data, 32'h0);
    check_eq("rst_ack", a_ack, 1'b0);
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_rdata", a_rdata, 32'h0);

    // Full-word store then load
    a_store(1'b0, {6'd3, 1'b0}, 32'hDEADBEEF, "st_w3");
    a_load(1'b0, {6'd3, 1'b0}, 32'hDEADBEEF, "ld_w3");
    a_disp_addr = 6'd3; #1;
    check_eq("disp_w3", a_disp_data, 32'hDEADBEEF);

`ifdef DM_RESP_HALF_EN
    // Upper wdata bits must be ignored on a half store
    a_store(1'b1, {6'd3, 1'b1}, 32'h5A5A8001, "hst_a7");
    a_disp_addr = 6'd3; #1;
    check_eq("disp_w3_half", a_disp_data, 32'h8001BEEF);
    a_load(1'b1, {6'd3, 1'b1}, 32'hFFFF8001, "hld_a7");
    a_load(1'b1, {6'd3, 1'b0}, 32'hFFFFBEEF, "hld_a6");
`else
    a_store(1'b1, {6'd0, 1'b1}, 32'hAAAA5555, "hst_a1");
    a_disp_addr = 6'd0; #1;
    check_eq("disp_w0_full", a_disp_data, 32'hAAAA5555);
    a_load(1'b1, {6'd3, 1'b1}, 32'hDEADBEEF, "hld_a7_full");
`endif

    // Zero wait states, req held across ack
    @(negedge clk);
    z_req = 1'b1; z_we = 1'b1; z_addr = {6'd1, 1'b0}; z_wdata = 32'h11110001;
    @(posedge clk); #1;
    check_eq("z_ack_first", z_ack, 1'b1);
    check_eq("z_busy_first", z_busy, 1'b1);
    @(negedge clk);
    z_addr = {6'd2, 1'b0}; z_wdata = 32'h22220002;
    @(posedge clk); #1;
    check_eq("z_ack_gap", z_ack, 1'b0);
    check_eq("z_busy_gap", z_busy, 1'b0);
    @(posedge clk); #1;
    check_eq("z_ack_second", z_ack, 1'b1);
    @(negedge clk);
    z_req = 1'b0; z_we = 1'b0;
    @(posedge clk); #1;
    check_eq("z_ack_done", z_ack, 1'b0);
    z_disp_addr = 6'd1; #1;
    check_eq("z_disp_w1", z_disp_data, 32'h11110001);
    z_disp_addr = 6'd2; #1;
    check_eq("z_disp_w2", z_disp_data, 32'h22220002);

    // Reset during WAIT aborts the store
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_half = 1'b0; a_addr = {6'd9, 1'b0}; a_wdata = 32'h12345678;
    @(posedge clk); #1;
    check_eq("rw_busy_wait", a_busy, 1'b1);
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0; a_we = 1'b0;
    #1;
    check_eq("rw_ack_rst", a_ack, 1'b0);
    check_eq("rw_busy_rst", a_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (a_ack) acks++;
    end
    check_eq("rw_no_ack", acks, 0);
    check_eq("rw_busy_idle", a_busy, 1'b0);
    a_disp_addr = 6'd9; #1;
    check_eq("rw_disp_w9", a_disp_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
